pipe_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the enable and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB buffer registers and the PC. It resolves three hazard types:
- load-use hazards, by inserting one bubble;
- EX-stage control redirects (branch taken, JAL, JALR), by flushing the two younger stages;
- multi-cycle data-memory accesses, by freezing the pipeline, with a timeout that halts the core.

---
 rtl/pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX redirects, data-memory waits with timeout.
// Optional macro HAZ_PERF_CNT_EN adds the stall_cnt / flush_cnt performance counter ports.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  input  logic       ifid_uses_rs2,
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rd,
  input  logic       ex_redirect,
  input  logic       exmem_mem_access,
  input  logic       dmem_ready,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       memwb_bubble,
  output logic [1:0] ctrl_state,
  output logic       halted
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT_C = MEM_TIMEOUT[7:0];

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_param_check
    $error("pipe_hazard_ctrl: MEM_TIMEOUT must be 1..255 and CNT_W at least 1");
  end

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       halted_q, halted_d;

  logic lu_s, mem_busy_s;
  logic pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s;
  logic ifid_flush_s, idex_flush_s, memwb_bubble_s;

  assign lu_s = idex_mem_read && (idex_rd != 5'd0) &&
                ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
  assign mem_busy_s = exmem_mem_access && !dmem_ready;

  // Next-state and Mealy control outputs; first matching hazard rule wins.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    halted_d       = halted_q;
    pc_en_s        = 1'b1;
    ifid_en_s      = 1'b1;
    idex_en_s      = 1'b1;
    exmem_en_s     = 1'b1;
    memwb_en_s     = 1'b1;
    ifid_flush_s   = 1'b0;
    idex_flush_s   = 1'b0;
    memwb_bubble_s = 1'b0;
    case (state_q)
      RUN, LU_STALL: begin
        if (mem_busy_s) begin
          pc_en_s        = 1'b0;
          ifid_en_s      = 1'b0;
          idex_en_s      = 1'b0;
          exmem_en_s     = 1'b0;
          memwb_bubble_s = 1'b1;
          state_d        = MEM_WAIT;
          wait_cnt_d     = 8'd1;
        end else if (ex_redirect) begin
          // The redirect discards any instruction a load-use stall would hold.
          ifid_flush_s = 1'b1;
          idex_flush_s = 1'b1;
          state_d      = RUN;
        end else if (lu_s && (state_q == RUN)) begin
          pc_en_s      = 1'b0;
          ifid_en_s    = 1'b0;
          idex_flush_s = 1'b1;
          state_d      = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else begin
          pc_en_s        = 1'b0;
          ifid_en_s      = 1'b0;
          idex_en_s      = 1'b0;
          exmem_en_s     = 1'b0;
          memwb_bubble_s = 1'b1;
          if (wait_cnt_q == TIMEOUT_C) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end else begin
            wait_cnt_d = wait_cnt_q;
          end
        end
      end
      HALT: begin
        pc_en_s        = 1'b0;
        ifid_en_s      = 1'b0;
        idex_en_s      = 1'b0;
        exmem_en_s     = 1'b0;
        memwb_en_s     = 1'b0;
        memwb_bubble_s = 1'b1;
        halted_d       = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  // While reset is held the whole pipeline is frozen and cleared.
  assign pc_en        = !reset && pc_en_s;
  assign ifid_en      = !reset && ifid_en_s;
  assign idex_en      = !reset && idex_en_s;
  assign exmem_en     = !reset && exmem_en_s;
  assign memwb_en     = !reset && memwb_en_s;
  assign ifid_flush   = reset || ifid_flush_s;
  assign idex_flush   = reset || idex_flush_s;
  assign memwb_bubble = reset || memwb_bubble_s;
  assign ctrl_state   = state_q;
  assign halted       = halted_q;

  // State, wait counter and sticky halt flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      halted_q   <= halted_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating counts of PC-stall cycles and IF/ID flush cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      if (!pc_en_s && (stall_cnt_q != CNT_MAX_C)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE_C;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (ifid_flush_s && (flush_cnt_q != CNT_MAX_C)) begin
        flush_cnt_q <= flush_cnt_q + CNT_ONE_C;
      end else begin
        flush_cnt_q <= flush_cnt_q;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
